// File: rtl/mul8_pkg.sv
// Shared types and constants for the 8x8 product accumulator stage.
// Saturating arithmetic is selected with the MUL8_ACC_SAT_EN macro.
package mul8_pkg;

  localparam int PROD_W    = 16;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mul8_acc_add.sv
// Combinational accumulator adder with carry-out overflow detection.
// Macro MUL8_ACC_SAT_EN: clamp to all-ones on overflow instead of wrapping.
module mul8_acc_add
  import mul8_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide;

  // One spare bit captures the carry out of the top accumulator bit.
  assign wide  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign carry = wide[ACC_W];

`ifdef MUL8_ACC_SAT_EN
  assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/mul8_acc_stage.sv
// Burst accumulator: sums cfg_len unsigned products and presents the total.
// Macro MUL8_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mul8_acc_stage
  import mul8_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  acc_state_t       state_reg;
  logic [LEN_W-1:0] remaining_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [ACC_W-1:0] sum_next;
  logic             carry_next;
  logic             beat;

  mul8_acc_add #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc  (acc_reg),
    .prod (in_prod),
    .sum  (sum_next),
    .carry(carry_next)
  );

  // in_ready_reg is only set in ACCUM, so this is the accept condition.
  assign beat = in_valid && in_ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            acc_reg  <= '0;
            ovf_reg  <= 1'b0;
            busy_reg <= 1'b1;
            if (cfg_len != '0) begin
              remaining_reg <= cfg_len;
              in_ready_reg  <= 1'b1;
              state_reg     <= ST_ACCUM;
            end else begin
              remaining_reg <= '0;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_OUTPUT;
            end
          end
        end

        ST_ACCUM: begin
          if (beat) begin
            acc_reg       <= sum_next;
            ovf_reg       <= ovf_reg | carry_next;
            remaining_reg <= remaining_reg - LEN_W'(1);
            if (remaining_reg == LEN_W'(1)) begin
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_OUTPUT;
            end
          end
        end

        ST_OUTPUT: begin
          // Result registers are untouched here, so they hold through a stall.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          remaining_reg <= '0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_sum   = acc_reg;
  assign out_ovf   = ovf_reg;

endmodule
